// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - Multi-cycle add/subtract unit, CHUNK bits per clock with a registered carry.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_cout;
  logic             chunk_cmsb;
  logic             ripple_c;
  logic [WIDTH-1:0] res_next;

  // Select the active chunk of each captured operand.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) begin
        chunk_a = a_reg[k*CHUNK +: CHUNK];
        chunk_b = b_reg[k*CHUNK +: CHUNK];
      end
    end
  end

  // Plain ripple inside the chunk; the carry into the top bit feeds overflow.
  always_comb begin
    chunk_s    = '0;
    ripple_c   = carry;
    chunk_cmsb = carry;
    for (int j = 0; j < CHUNK; j++) begin
      if (j == CHUNK - 1) begin
        chunk_cmsb = ripple_c;
      end
      chunk_s[j] = chunk_a[j] ^ chunk_b[j] ^ ripple_c;
      ripple_c   = (chunk_a[j] & chunk_b[j]) | (ripple_c & (chunk_a[j] ^ chunk_b[j]));
    end
    chunk_cout = ripple_c;
  end

  always_comb begin
    res_next = res_reg;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) begin
        res_next[k*CHUNK +: CHUNK] = chunk_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // Subtract is a + ~b + !cin, so the borrow-in becomes an inverted carry-in.
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            idx   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          carry   <= chunk_cout;
          res_reg <= res_next;
          if (idx == LAST_IDX) begin
            sum      <= res_next;
            cout     <= chunk_cout;
            overflow <= chunk_cmsb ^ chunk_cout;
            idx      <= '0;
            state    <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb/tb_chunked_serial_adder.sv - Self-checking bench for chunked_serial_adder across three parameter sets.
module tb_chunked_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: 16/4, instance 1: 8/8, instance 2: 32/1
  logic        start0, cin0, sub0, busy0, done0, cout0, ovf0;
  logic [15:0] a0, b0, sum0;
  logic        start1, cin1, sub1, busy1, done1, cout1, ovf1;
  logic [7:0]  a1, b1, sum1;
  logic        start2, cin2, sub2, busy2, done2, cout2, ovf2;
  logic [31:0] a2, b2, sum2;

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .cin(cin0), .sub(sub0),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .overflow(ovf0));
  chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));
  chunked_serial_adder #(.WIDTH(32), .CHUNK(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ovf2));

  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic        obs_busy, obs_done, obs_cout, obs_ovf;
  logic [31:0] obs_sum;

  always_comb begin
    obs_busy = busy0; obs_done = done0; obs_cout = cout0; obs_ovf = ovf0; obs_sum = {16'h0, sum0};
    case (sel)
      1: begin obs_busy = busy1; obs_done = done1; obs_cout = cout1; obs_ovf = ovf1; obs_sum = {24'h0, sum1}; end
      2: begin obs_busy = busy2; obs_done = done2; obs_cout = cout2; obs_ovf = ovf2; obs_sum = sum2; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int width_of(input int s);
    return (s == 0) ? 16 : (s == 1) ? 8 : 32;
  endfunction

  function automatic int chunks_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 1 : 32;
  endfunction

  // Reference: {overflow, cout, sum} from integer arithmetic on the operand values.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] mask, ua, ub, full;
    longint sa, sb, r, hi, lo;
    logic ovf;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'h0, a} & mask;
    ub = {32'h0, b} & mask;
    full = sub ? ua + (~ub & mask) + {63'h0, ~cin} : ua + ub + {63'h0, cin};
    sa = longint'(ua);
    if (ua[w-1]) sa = sa - (longint'(1) << w);
    sb = longint'(ub);
    if (ub[w-1]) sb = sb - (longint'(1) << w);
    r  = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    ovf = (r > hi) || (r < lo);
    return {ovf, full[w], full[31:0] & mask[31:0]};
  endfunction

  task automatic set_in(input int s, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic st);
    case (s)
      0: begin a0 = a[15:0]; b0 = b[15:0]; cin0 = cin; sub0 = sub; start0 = st; end
      1: begin a1 = a[7:0];  b1 = b[7:0];  cin1 = cin; sub1 = sub; start1 = st; end
      default: begin a2 = a; b2 = b; cin2 = cin; sub2 = sub; start2 = st; end
    endcase
  endtask

  task automatic do_op(input int s, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input string tag);
    int n;
    int lat;
    int bcnt;
    int both;
    logic [33:0] exp;
    n    = chunks_of(s);
    exp  = model(width_of(s), a, b, cin, sub);
    lat  = -1;
    bcnt = 0;
    both = 0;
    sel  = s;
    @(negedge clk);
    set_in(s, a, b, cin, sub, 1'b1);
    for (int k = 1; k <= n + 4; k++) begin
      @(negedge clk);
      if (k == 1) set_in(s, a, b, cin, sub, 1'b0);
      if (obs_busy && obs_done) both++;
      if (obs_busy) bcnt++;
      if (obs_done) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(n + 1));
    check({tag, " busy_cycles"}, 64'(bcnt), 64'(n));
    check({tag, " busy_and_done"}, 64'(both), 64'd0);
    check({tag, " sum"}, {32'h0, obs_sum}, {32'h0, exp[31:0]});
    check({tag, " cout"}, {63'h0, obs_cout}, {63'h0, exp[32]});
    check({tag, " overflow"}, {63'h0, obs_ovf}, {63'h0, exp[33]});
    @(negedge clk);
    check({tag, " done_single"}, {63'h0, obs_done}, 64'd0);
  endtask

  initial begin
    int dones;
    int bad;
    logic [31:0] ra, rb;
    logic [31:0] first_sum;

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0, 0);
    set_in(2, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset busy", {61'h0, busy0, busy1, busy2}, 64'd0);
    check("reset done", {61'h0, done0, done1, done2}, 64'd0);
    check("reset sum", {sum2, sum0, sum1, 8'h0}, 64'd0);
    check("reset flags", {58'h0, cout0, cout1, cout2, ovf0, ovf1, ovf2}, 64'd0);
    rst = 1'b0;

    do_op(0, 32'h000C, 32'h000A, 1'b0, 1'b0, "add_small");
    do_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, "add_carry");
    do_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, "add_ovf");
    do_op(0, 32'h0009, 32'h0006, 1'b1, 1'b0, "add_cin");
    do_op(0, 32'h0005, 32'h0003, 1'b0, 1'b1, "sub_pos");
    do_op(0, 32'h0003, 32'h0005, 1'b0, 1'b1, "sub_borrow");
    do_op(0, 32'h8000, 32'h0001, 1'b0, 1'b1, "sub_ovf");
    do_op(0, 32'h0010, 32'h0003, 1'b1, 1'b1, "sub_bin");

    // start during RUN must be ignored
    sel = 0;
    dones = 0;
    first_sum = 32'h0;
    @(negedge clk);
    set_in(0, 32'h1234, 32'h1111, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start0 = 1'b0;
      if (k == 2) set_in(0, 32'hFFFF, 32'hFFFF, 1'b1, 1'b1, 1'b1);
      if (k == 3) start0 = 1'b0;
      if (obs_done) begin
        dones++;
        if (dones == 1) first_sum = obs_sum;
      end
    end
    check("run_start dones", 64'(dones), 64'd1);
    check("run_start sum", {32'h0, first_sum}, 64'h2345);

    // start held high: one accept and one done every N+1 cycles
    dones = 0;
    bad = 0;
    @(negedge clk);
    set_in(0, 32'h0100, 32'h0203, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (obs_done) begin
        dones++;
        if ((k % 5) != 0) bad++;
      end
      if (k == 15) start0 = 1'b0;
    end
    check("held dones", 64'(dones), 64'd3);
    check("held spacing", 64'(bad), 64'd0);
    check("held sum", {32'h0, obs_sum}, 64'h0303);
    repeat (3) @(negedge clk);

    // reset in the second RUN cycle abandons the operation
    @(negedge clk);
    set_in(0, 32'h1111, 32'h2222, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    check("pre_rst busy", {63'h0, obs_busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", {63'h0, obs_busy}, 64'd0);
    check("rst done", {63'h0, obs_done}, 64'd0);
    check("rst sum", {32'h0, obs_sum}, 64'd0);
    check("rst flags", {62'h0, obs_cout, obs_ovf}, 64'd0);
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (obs_done) dones++;
    end
    check("rst no_done", 64'(dones), 64'd0);
    do_op(0, 32'hABCD, 32'h1234, 1'b0, 1'b0, "post_rst");

    do_op(1, 32'h00FF, 32'h0001, 1'b0, 1'b0, "w8_carry");
    do_op(1, 32'h007F, 32'h0001, 1'b0, 1'b0, "w8_ovf");
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      do_op(1, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "w8_rand");
    end

    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom;
      if (i == 0) begin ra = 32'h8000; rb = 32'h8000; end
      do_op(0, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "w16_rand");
    end

    do_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "w32_carry");
    do_op(2, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, "w32_sub_ovf");
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      do_op(2, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "w32_rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
